// File: rtl/tbuf_arb_pkg.sv
// Shared types and widths for the tristate-bus drive-enable arbiter.
package tbuf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    localparam int unsigned TURN_W = 3;
    localparam int unsigned HOLD_W = 8;

endpackage

// File: rtl/tbuf_rr_pick.sv
// Round-robin picker: first requester at or above ptr_i, wrapping at N-1.
module tbuf_rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     win_oh_o,
    output logic [IDX_W-1:0] win_idx_o
);

    // Walk the request vector in rotated order and stop at the first hit.
    always_comb begin
        logic        found;
        int unsigned j;
        found     = 1'b0;
        j         = 0;
        win_oh_o  = '0;
        win_idx_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(ptr_i) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req_i[IDX_W'(j)]) begin
                found                  = 1'b1;
                win_idx_o              = IDX_W'(j);
                win_oh_o[IDX_W'(j)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tbuf_bus_arbiter.sv
// Round-robin TBUF drive-enable controller with break-before-make turnaround.
// Optional grant-length limit enabled by defining TBUF_ARB_HOLD_TIMEOUT_EN.
module tbuf_bus_arbiter
    import tbuf_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS   = 4,
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned MAX_HOLD    = 16
) (
    input  logic                         CLK,
    input  logic                         R,
    input  logic [N_MASTERS-1:0]         req,
    output logic [N_MASTERS-1:0]         gnt,
    output logic [N_MASTERS-1:0]         drv_en,
    output logic [$clog2(N_MASTERS)-1:0] owner,
    output logic                         busy,
    output logic                         bus_float,
    output logic                         timeout
);

    localparam int unsigned IDX_W = $clog2(N_MASTERS);

    if (N_MASTERS < 2 || N_MASTERS > 16 || TURN_CYCLES > 7 || MAX_HOLD < 2 || MAX_HOLD > 255)
    begin : g_bad_param
        $error("tbuf_bus_arbiter: parameter out of range");
    end

    arb_state_t           state_q, state_d;
    logic [N_MASTERS-1:0] drv_en_q, drv_en_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [TURN_W-1:0]    turn_q, turn_d;
    logic [N_MASTERS-1:0] win_oh;
    logic [IDX_W-1:0]     win_idx;
    logic                 release_c;
`ifdef TBUF_ARB_HOLD_TIMEOUT_EN
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 timeout_q, timeout_d;
`endif

    tbuf_rr_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        drv_en_d  = drv_en_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        turn_d    = turn_q;
        release_c = 1'b0;
`ifdef TBUF_ARB_HOLD_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d  = GRANT;
                    drv_en_d = win_oh;
                    owner_d  = win_idx;
                    ptr_d    = (win_idx == IDX_W'(N_MASTERS - 1)) ? '0 : win_idx + IDX_W'(1);
`ifdef TBUF_ARB_HOLD_TIMEOUT_EN
                    hold_d   = '0;
`endif
                end
            end
            GRANT: begin
`ifdef TBUF_ARB_HOLD_TIMEOUT_EN
                hold_d = hold_q + HOLD_W'(1);
                if (!req[owner_q]) begin
                    release_c = 1'b1;
                end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    release_c = 1'b1;
                    timeout_d = 1'b1;
                end
`else
                release_c = ~req[owner_q];
`endif
                if (release_c) begin
                    drv_en_d = '0;
                    turn_d   = '0;
                    state_d  = (TURN_CYCLES == 0) ? IDLE : TURN;
                end
            end
            TURN: begin
                if (turn_q == TURN_W'(TURN_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    turn_d = turn_q + TURN_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                drv_en_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q  <= IDLE;
            drv_en_q <= '0;
            owner_q  <= '0;
            ptr_q    <= '0;
            turn_q   <= '0;
        end else begin
            state_q  <= state_d;
            drv_en_q <= drv_en_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            turn_q   <= turn_d;
        end
    end

`ifdef TBUF_ARB_HOLD_TIMEOUT_EN
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Status flags derive straight from the enable register so the keeper tracks the TBUFs.
    assign gnt       = drv_en_q;
    assign drv_en    = drv_en_q;
    assign owner     = owner_q;
    assign busy      = |drv_en_q;
    assign bus_float = ~(|drv_en_q);

    a_onehot_drv : assert property (@(posedge CLK) disable iff (!R) $onehot0(drv_en_q));

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Directed and randomized checks of the TBUF drive-enable arbiter (N=4, TURN_CYCLES=1, MAX_HOLD=4).
module tb_tbuf_bus_arbiter;

    logic       CLK;
    logic       R;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] drv_en;
    logic [1:0] owner;
    logic       busy;
    logic       bus_float;
    logic       timeout;

    int checks   = 0;
    int failures = 0;
    int zrun     = 0;

    tbuf_bus_arbiter #(
        .N_MASTERS   (4),
        .TURN_CYCLES (1),
        .MAX_HOLD    (4)
    ) dut (
        .CLK       (CLK),
        .R         (R),
        .req       (req),
        .gnt       (gnt),
        .drv_en    (drv_en),
        .owner     (owner),
        .busy      (busy),
        .bus_float (bus_float),
        .timeout   (timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        R   = 1'b0;
        req = 4'h0;

        // Reset values
        #12;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_float", 32'(bus_float), 32'h1);
        chk("rst_timeout", 32'(timeout), 32'h0);
        R = 1'b1;
        tick();
        chk("idle_gnt", 32'(gnt), 32'h0);

        // Single request, one-cycle latency
        req = 4'h1;
        chk("lat_before", 32'(gnt), 32'h0);
        tick();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_drv", 32'(drv_en), 32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_float", 32'(bus_float), 32'h0);
        chk("t1_owner", 32'(owner), 32'h0);

        // All request: rotation 0,1,2,3,0 with two zero cycles between grants
        req = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_hold", 32'(gnt), 32'd1 << k);
            tick();
            chk("rr_hold2", 32'(gnt), 32'd1 << k);
            req = 4'hF & ~4'(1 << k);
            tick();
            chk("rr_rel", 32'(drv_en), 32'h0);
            chk("rr_rel_float", 32'(bus_float), 32'h1);
            req = 4'hF;
            tick();
            chk("rr_turn", 32'(drv_en), 32'h0);
            tick();
            chk("rr_next", 32'(gnt), 32'd1 << ((k + 1) % 4));
            chk("rr_owner", 32'(owner), 32'((k + 1) % 4));
        end

        // Owner 0 releases with only master 2 asking: ptr=1 finds 2
        req = 4'h4;
        tick();
        chk("t3_rel0", 32'(drv_en), 32'h0);
        tick();
        tick();
        chk("t3_gnt2", 32'(gnt), 32'h4);
        req = 4'h5;
        tick();
        chk("t3_ignore", 32'(gnt), 32'h4);
        req = 4'h1;
        tick();
        chk("t3_drop", 32'(drv_en), 32'h0);
        chk("t3_float1", 32'(bus_float), 32'h1);
        req = 4'h2;
        tick();
        chk("t3_float2", 32'(bus_float), 32'h1);
        req = 4'h1;
        tick();
        chk("t3_wrap", 32'(gnt), 32'h1);
        chk("t3_owner", 32'(owner), 32'h0);

        // Asynchronous reset mid-grant; ptr returns to 0
        req = 4'hF;
        #2;
        R = 1'b0;
        #1;
        chk("t4_drv", 32'(drv_en), 32'h0);
        chk("t4_float", 32'(bus_float), 32'h1);
        #1;
        R = 1'b1;
        tick();
        chk("t4_first", 32'(gnt), 32'h1);

        // Sole requester 1: hold limit (when built in) then re-grant after the gap
        req = 4'h2;
        tick();
        chk("t5_rel", 32'(drv_en), 32'h0);
        tick();
        tick();
        chk("t5_gnt", 32'(gnt), 32'h2);
        tick();
        chk("t5_c2", 32'(gnt), 32'h2);
        tick();
        chk("t5_c3", 32'(gnt), 32'h2);
        tick();
        chk("t5_c4", 32'(gnt), 32'h2);
        chk("t5_c4_to", 32'(timeout), 32'h0);
        tick();
`ifdef TBUF_ARB_HOLD_TIMEOUT_EN
        chk("t5_force", 32'(drv_en), 32'h0);
        chk("t5_to", 32'(timeout), 32'h1);
        tick();
        chk("t5_gap", 32'(drv_en), 32'h0);
        chk("t5_to_end", 32'(timeout), 32'h0);
`else
        chk("t5_nolimit", 32'(drv_en), 32'h2);
        chk("t5_to", 32'(timeout), 32'h0);
        tick();
        chk("t5_nolimit2", 32'(drv_en), 32'h2);
`endif
        tick();
        chk("t5_regrant", 32'(gnt), 32'h2);

        // Random requests: one-hot enables, consistent flags, turnaround gap
        zrun = 0;
        for (int c = 0; c < 3000; c++) begin
            req = 4'($urandom_range(0, 15));
            tick();
            chk("rnd_onehot", 32'($onehot0(drv_en)), 32'h1);
            chk("rnd_gnt_eq", 32'(gnt), 32'(drv_en));
            chk("rnd_float", 32'(bus_float), 32'(drv_en == 4'h0));
            if (drv_en == 4'h0) begin
                zrun++;
            end else begin
                chk("rnd_owner", 32'(drv_en), 32'd1 << owner);
                if (zrun != 0) begin
                    chk("rnd_gap", 32'(zrun >= 2), 32'h1);
                end
                zrun = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
